gaus_window_buffer: RTL

Stream-to-window stage of the Gaussian buffer block. It sits directly downstream of the beat counter and consumes its `process`, `started` and `pixelCounter` outputs together with the pixel data read from image memory. It turns the raster pixel stream into a 3x3 neighbourhood window, one window per interior pixel, for the Gaussian kernel stage. It also checks that the address stream from the beat counter stays in sequence.

---
 rtl/gaus_pkg.sv | 20 ++
 rtl/gaus_line_fifo.sv | 41 ++++
 rtl/gaus_window_buffer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gaus_pkg.sv
// Shared types and helpers for the Gaussian window buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gaus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } gausState_t;

   localparam int WINDOW_TAPS = 9;

   // Flat index of tap (r,c); r=0 is the oldest row, c=0 the oldest column.
   function automatic int tapIndex(input int r, input int c);
      return 3 * r + c;
   endfunction

endpackage

// File: rtl/gaus_line_fifo.sv
// Shift-enabled delay line of DEPTH entries: dataOut is the word written DEPTH shifts ago.
// Latency: DEPTH shift events; dataOut is combinational from the current read slot.
// Backpressure: none; shifts whenever 'shift' is high.
//
// Ports: clk, reset (sync, active-high, clears pointer only), shift (advance),
//        dataIn (word entering), dataOut (word leaving this shift).
module gaus_line_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift,
   input  logic [WIDTH-1:0] dataIn,
   output logic [WIDTH-1:0] dataOut
);

   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTRW-1:0]  ptr;

   // Read and write share one slot: the word read out is the one being overwritten.
   assign dataOut = mem[ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (shift) begin
         ptr <= (ptr == PTRW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
      end
   end

   // Contents are deliberately not reset; the consumer masks stale data.
   always_ff @(posedge clk) begin
      if (shift) begin
         mem[ptr] <= dataIn;
      end
   end

endmodule

// File: rtl/gaus_window_buffer.sv
// Raster pixel stream to 3x3 window converter with address-sequence checking.
// Latency: 1 cycle from accept to window/windowValid/centreAddr (2 with GAUS_WINDOW_REG_EN).
// Backpressure: none; one pixel accepted per rising edge of 'process' while 'started'.
//
// Ports: clk, reset (sync, active-high); process/started/pixelCounter/pixelIn from
//        the beat counter and image memory; window (9 taps, tap (r,c) at
//        [PIXELWIDTH*(3r+c)]), windowValid, centreAddr (address of tap (1,1)),
//        frameDone (one-cycle pulse), syncError (sticky until reset).
// Build option: define GAUS_WINDOW_REG_EN to add one output register stage.
module gaus_window_buffer
   import gaus_pkg::*;
#(
   parameter int LINEWIDTH         = 16,
   parameter int LINES             = 16,
   parameter int PIXELWIDTH        = 8,
   parameter int PIXELCOUNTERWIDTH = 20
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         process,
   input  logic                         started,
   input  logic [PIXELCOUNTERWIDTH-1:0] pixelCounter,
   input  logic [PIXELWIDTH-1:0]        pixelIn,
   output logic [9*PIXELWIDTH-1:0]      window,
   output logic                         windowValid,
   output logic [PIXELCOUNTERWIDTH-1:0] centreAddr,
   output logic                         frameDone,
   output logic                         syncError
);

   localparam int COLW        = (LINEWIDTH > 1) ? $clog2(LINEWIDTH) : 1;
   localparam int ROWW        = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int FRAMEPIXELS = LINEWIDTH * LINES;

   gausState_t state, stateNext;

   logic                         processPrev;
   logic                         accept;
   logic [COLW-1:0]              col;
   logic [ROWW-1:0]              row;
   logic [PIXELCOUNTERWIDTH-1:0] addr;

   logic [PIXELWIDTH-1:0]        taps [WINDOW_TAPS];
   logic [PIXELWIDTH-1:0]        midIn;
   logic [PIXELWIDTH-1:0]        topIn;
   logic [9*PIXELWIDTH-1:0]      windowPacked;

   logic                         advance;
   logic                         clearCount;
   logic                         syncSet;
   logic                         windowValidNext;
   logic                         frameDoneNext;
   logic                         interior;
   logic                         lastPixel;
   logic                         addrMismatch;

   logic                         windowValidQ;
   logic                         frameDoneQ;
   logic [PIXELCOUNTERWIDTH-1:0] centreAddrQ;

   // Only the first beat of each upstream beat group is taken.
   assign accept       = process && !processPrev && started;
   assign interior     = (row >= ROWW'(2)) && (col >= COLW'(2));
   assign lastPixel    = (addr == PIXELCOUNTERWIDTH'(FRAMEPIXELS - 1));
   assign addrMismatch = (pixelCounter != addr);

   // Line delays: midIn is the pixel one row above the newest, topIn two rows above.
   gaus_line_fifo #(.DEPTH(LINEWIDTH), .WIDTH(PIXELWIDTH)) u_lineMid (
      .clk     (clk),
      .reset   (reset),
      .shift   (advance),
      .dataIn  (pixelIn),
      .dataOut (midIn)
   );

   gaus_line_fifo #(.DEPTH(LINEWIDTH), .WIDTH(PIXELWIDTH)) u_lineTop (
      .clk     (clk),
      .reset   (reset),
      .shift   (advance),
      .dataIn  (midIn),
      .dataOut (topIn)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext       = state;
      advance         = 1'b0;
      clearCount      = 1'b0;
      syncSet         = 1'b0;
      windowValidNext = 1'b0;
      frameDoneNext   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               advance   = 1'b1;
               syncSet   = addrMismatch;
               stateNext = FILL;
            end
         end
         FILL, STREAM: begin
            if (!started) begin
               // Upstream abandoned the frame: flag it and rearm for address 0.
               syncSet    = 1'b1;
               clearCount = 1'b1;
               stateNext  = IDLE;
            end else if (accept) begin
               advance         = 1'b1;
               syncSet         = addrMismatch;
               // col<2 windows straddle a row boundary and are suppressed.
               windowValidNext = interior;
               if (lastPixel) begin
                  clearCount = 1'b1;
                  stateNext  = DONE;
               end else if (interior) begin
                  stateNext = STREAM;
               end
            end
         end
         DONE: begin
            frameDoneNext = 1'b1;
            stateNext     = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         processPrev  <= 1'b0;
         col          <= '0;
         row          <= '0;
         addr         <= '0;
         windowValidQ <= 1'b0;
         frameDoneQ   <= 1'b0;
         centreAddrQ  <= '0;
         syncError    <= 1'b0;
         for (int i = 0; i < WINDOW_TAPS; i++) begin
            taps[i] <= '0;
         end
      end else begin
         processPrev  <= process;
         windowValidQ <= windowValidNext;
         frameDoneQ   <= frameDoneNext;
         if (syncSet) begin
            syncError <= 1'b1;
         end

         // The internal count, not pixelCounter, defines the pixel position.
         if (clearCount) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
         end else if (advance) begin
            addr <= addr + 1'b1;
            if (col == COLW'(LINEWIDTH - 1)) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end

         if (advance) begin
            for (int r = 0; r < 3; r++) begin
               taps[tapIndex(r, 0)] <= taps[tapIndex(r, 1)];
               taps[tapIndex(r, 1)] <= taps[tapIndex(r, 2)];
            end
            taps[tapIndex(0, 2)] <= topIn;
            taps[tapIndex(1, 2)] <= midIn;
            taps[tapIndex(2, 2)] <= pixelIn;
         end

         if (windowValidNext) begin
            centreAddrQ <= addr - PIXELCOUNTERWIDTH'(LINEWIDTH + 1);
         end
      end
   end

   always_comb begin
      windowPacked = '0;
      for (int i = 0; i < WINDOW_TAPS; i++) begin
         windowPacked[PIXELWIDTH*i +: PIXELWIDTH] = taps[i];
      end
   end

`ifdef GAUS_WINDOW_REG_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         window      <= '0;
         windowValid <= 1'b0;
         centreAddr  <= '0;
         frameDone   <= 1'b0;
      end else begin
         window      <= windowPacked;
         windowValid <= windowValidQ;
         centreAddr  <= centreAddrQ;
         frameDone   <= frameDoneQ;
      end
   end
`else
   assign window      = windowPacked;
   assign windowValid = windowValidQ;
   assign centreAddr  = centreAddrQ;
   assign frameDone   = frameDoneQ;
`endif

endmodule
